vde_line_packer: RTL and testbench
==================================

VDE_LINE_PACKER -- requirements
Module: vde_line_packer

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 320; bytes per video line; legal range 1..65535.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data_in_valid_i  input  1  upstream byte valid.
REQ-005 SHALL have port data_in_ready_o  output  1  byte accepted when valid and ready are both high.
REQ-006 SHALL have port data_in_data_i  input  8  input byte.
REQ-007 SHALL have port data_out_valid_o  output  1  packed word valid.
REQ-008 SHALL have port data_out_ready_i  input  1  word consumed when valid and ready are both high.
REQ-009 SHALL have port data_out_data_o  output  32  packed word; byte lane k occupies bits 8k+7:8k.
REQ-010 SHALL have port data_out_strb_o  output  4  lane enables for data_out_data_o.
REQ-011 SHALL have port data_out_last_o  output  1  word holds the final byte of a line.
REQ-012 SHALL have port lines_done_o  output  16  count of line-final words consumed, modulo 2^16.

Function
REQ-013 SHALL place accepted bytes little-endian: the first byte of each word goes in lane 0, the next in lane 1, and so on.
REQ-014 SHALL keep a lane counter (0..3) and a line byte counter (0..LINE_BYTES-1); both advance on every accepted byte.
REQ-015 SHALL define a closing byte as an accepted byte at lane 3, or an accepted byte whose line byte counter equals LINE_BYTES-1.
REQ-016 SHALL, when a closing byte is accepted, load the output register on the same edge with the accumulated lanes plus the closing byte; latency from closing byte to data_out_valid_o high is 1 cycle.
REQ-017 SHALL drive strb bits high for the filled lanes only (contiguous from lane 0), and SHALL drive unfilled lanes of data_out_data_o as 0x00.
REQ-018 SHALL drive data_out_last_o high only when the closing byte was the line's final byte; lane and line counters then reset to 0 and the next byte starts a new word in lane 0.
REQ-019 SHALL drive data_in_ready_o low only when all three hold: the next byte would be closing (lane==3 or line counter==LINE_BYTES-1), data_out_valid_o is high, and data_out_ready_i is low; otherwise it SHALL be high.
REQ-020 SHALL allow one output word to be consumed and a new one loaded on the same edge, sustaining 1 byte/cycle with no bubble when data_out_ready_i stays high.
REQ-021 SHALL hold data_out_valid_o, data, strb and last stable while valid is high and ready is low.
REQ-022 SHALL clear data_out_valid_o after a consume edge unless a closing byte is accepted on that same edge.
REQ-023 SHALL increment lines_done_o on each consume edge where data_out_last_o is high, wrapping from 0xFFFF to 0x0000.
REQ-024 SHALL, for LINE_BYTES not a multiple of 4, emit a partial final word per line (e.g. LINE_BYTES=6: strb 1111, then 0011 with last).
REQ-025 SHALL, for LINE_BYTES=1, treat every byte as closing: strb 0001 and last set on every word.
REQ-026 SHALL ignore data_in_data_i when data_in_valid_i is low, and SHALL insert no padding words between lines.

Reset
REQ-027 SHALL, while rst_i is high, clear the lane counter, line counter, accumulator, data_out_valid_o, data_out_data_o, data_out_strb_o, data_out_last_o and lines_done_o to 0, with effect immediate and independent of clk_i.
REQ-028 SHALL drive data_in_ready_o high during and after reset, since no word is pending.
REQ-029 SHALL, on reset asserted mid-line or mid-word, discard the partial word and any pending output word; the first byte after release is lane 0 of line byte 0.

Verification
REQ-030 SHALL verify, with LINE_BYTES=8 and ready high, bytes 01..08 on consecutive cycles -> words 0x04030201 strb F last 0, then 0x08070605 strb F last 1; lines_done_o=1; no stall cycles.
REQ-031 SHALL verify, with LINE_BYTES=6, bytes 11..16 -> 0x14131211 strb F last 0, then 0x00001615 strb 3 last 1.
REQ-032 SHALL verify backpressure: with LINE_BYTES=8 and data_out_ready_i low, 8 bytes offered -> after the first word forms, input stalls at the 8th byte (ready low); the held word stays stable; on release, both words emerge in order with no loss.
REQ-033 SHALL verify, with LINE_BYTES=1, bytes AA,BB -> words 0x000000AA and 0x000000BB, each strb 1, last 1; lines_done_o=2.
REQ-034 SHALL verify that rst_i pulsed after 3 of 8 bytes of a line -> all outputs 0 immediately; the next 8 bytes produce a correct fresh line with lines_done_o=1.
REQ-035 SHALL verify 65536 lines at LINE_BYTES=1 -> lines_done_o wraps to 0x0000.

Source files
------------

// File: rtl/vde_line_packer.sv
// rtl/vde_line_packer.sv - packs a byte stream into 32-bit little-endian words, closing a word at lane 3 or at line end
module vde_line_packer #(
  parameter int unsigned LINE_BYTES = 320
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_in_valid_i,
  output logic        data_in_ready_o,
  input  logic [7:0]  data_in_data_i,
  output logic        data_out_valid_o,
  input  logic        data_out_ready_i,
  output logic [31:0] data_out_data_o,
  output logic [3:0]  data_out_strb_o,
  output logic        data_out_last_o,
  output logic [15:0] lines_done_o
);

  localparam logic [15:0] LINE_LAST = 16'(LINE_BYTES - 1);

  logic [1:0]  lane_q;
  logic [15:0] line_pos_q;
  logic [23:0] acc_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic [3:0]  out_strb_q;
  logic        out_last_q;
  logic [15:0] lines_done_q;

  logic        line_end;
  logic        closing_next;
  logic        accept;
  logic        consume;
  logic [31:0] word_next;
  logic [3:0]  strb_next;

  assign line_end     = (line_pos_q == LINE_LAST);
  assign closing_next = (lane_q == 2'd3) || line_end;

  // Only a closing byte needs the output register, so only it can be blocked.
  assign data_in_ready_o = !(closing_next && out_valid_q && !data_out_ready_i);
  assign accept          = data_in_valid_i && data_in_ready_o;
  assign consume         = out_valid_q && data_out_ready_i;

  always_comb begin
    word_next = '0;
    strb_next = '0;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < lane_q) begin
        word_next[8*k +: 8] = acc_q[8*k +: 8];
        strb_next[k]        = 1'b1;
      end
    end
    word_next[{lane_q, 3'b000} +: 8] = data_in_data_i;
    strb_next[lane_q]                = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q       <= '0;
      line_pos_q   <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_last_q   <= 1'b0;
      lines_done_q <= '0;
    end else begin
      if (consume) begin
        out_valid_q <= 1'b0;
        if (out_last_q) begin
          lines_done_q <= lines_done_q + 16'd1;
        end
      end
      if (accept) begin
        if (closing_next) begin
          out_valid_q <= 1'b1;
          out_data_q  <= word_next;
          out_strb_q  <= strb_next;
          out_last_q  <= line_end;
        end else begin
          case (lane_q)
            2'd0:    acc_q[7:0]   <= data_in_data_i;
            2'd1:    acc_q[15:8]  <= data_in_data_i;
            2'd2:    acc_q[23:16] <= data_in_data_i;
            default: ;
          endcase
        end
        lane_q     <= line_end ? 2'd0 : lane_q + 2'd1;
        line_pos_q <= line_end ? 16'd0 : line_pos_q + 16'd1;
      end
    end
  end

  assign data_out_valid_o = out_valid_q;
  assign data_out_data_o  = out_data_q;
  assign data_out_strb_o  = out_strb_q;
  assign data_out_last_o  = out_last_q;
  assign lines_done_o     = lines_done_q;

endmodule

// File: tb/tb_vde_line_packer.sv
// tb/tb_vde_line_packer.sv - self-checking bench for vde_line_packer at LINE_BYTES 8, 6 and 1
module tb_vde_line_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v     [3];
  logic [7:0]  d     [3];
  logic        ordy  [3];
  logic        irdy  [3];
  logic        oval  [3];
  logic [31:0] odat  [3];
  logic [3:0]  ostrb [3];
  logic        olast [3];
  logic [15:0] lines [3];

  int checks = 0;
  int errors = 0;
  int lbs [3] = '{8, 6, 1};

  vde_line_packer #(.LINE_BYTES(8)) u_lb8 (
    .clk_i(clk), .rst_i(rst),
    .data_in_valid_i(v[0]), .data_in_ready_o(irdy[0]), .data_in_data_i(d[0]),
    .data_out_valid_o(oval[0]), .data_out_ready_i(ordy[0]), .data_out_data_o(odat[0]),
    .data_out_strb_o(ostrb[0]), .data_out_last_o(olast[0]), .lines_done_o(lines[0])
  );

  vde_line_packer #(.LINE_BYTES(6)) u_lb6 (
    .clk_i(clk), .rst_i(rst),
    .data_in_valid_i(v[1]), .data_in_ready_o(irdy[1]), .data_in_data_i(d[1]),
    .data_out_valid_o(oval[1]), .data_out_ready_i(ordy[1]), .data_out_data_o(odat[1]),
    .data_out_strb_o(ostrb[1]), .data_out_last_o(olast[1]), .lines_done_o(lines[1])
  );

  vde_line_packer #(.LINE_BYTES(1)) u_lb1 (
    .clk_i(clk), .rst_i(rst),
    .data_in_valid_i(v[2]), .data_in_ready_o(irdy[2]), .data_in_data_i(d[2]),
    .data_out_valid_o(oval[2]), .data_out_ready_i(ordy[2]), .data_out_data_o(odat[2]),
    .data_out_strb_o(ostrb[2]), .data_out_last_o(olast[2]), .lines_done_o(lines[2])
  );

  typedef struct {
    bit          rst_before;
    int          inst;
    bit          vv;
    logic [7:0]  dd;
    bit          e_val;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    bit          e_last;
    logic [15:0] e_lines;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, int i, bit vv, logic [7:0] dd, bit e_val,
                              logic [31:0] e_data, logic [3:0] e_strb, bit e_last, logic [15:0] e_lines);
    vec_t t;
    t.rst_before = r; t.inst = i; t.vv = vv; t.dd = dd; t.e_val = e_val;
    t.e_data = e_data; t.e_strb = e_strb; t.e_last = e_last; t.e_lines = e_lines;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; d[i] = 8'h00; ordy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_random(input int i, input int ncyc, input int pv, input int pr);
    logic [7:0]  pend [$];
    logic [31:0] eq_d [$];
    logic [3:0]  eq_s [$];
    bit          eq_l [$];
    logic [31:0] w;
    int          pos;
    int          mlines;
    int          lb;
    bit          exp_rdy;
    pos = 0; mlines = 0; lb = lbs[i];
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      v[i]    = ($urandom_range(99) < pv);
      d[i]    = 8'($urandom);
      ordy[i] = ($urandom_range(99) < pr);
      @(negedge clk);
      exp_rdy = !(((pend.size() == 3) || (pos == lb - 1)) && (eq_d.size() > 0) && !ordy[i]);
      chk($sformatf("rnd%0d_ready", i), 32'(irdy[i]), 32'(exp_rdy));
      chk($sformatf("rnd%0d_valid", i), 32'(oval[i]), 32'(eq_d.size() > 0));
      if (eq_d.size() > 0) begin
        chk($sformatf("rnd%0d_data", i), odat[i], eq_d[0]);
        chk($sformatf("rnd%0d_strb", i), 32'(ostrb[i]), 32'(eq_s[0]));
        chk($sformatf("rnd%0d_last", i), 32'(olast[i]), 32'(eq_l[0]));
      end
      chk($sformatf("rnd%0d_lines", i), 32'(lines[i]), 32'(16'(mlines)));
      if ((eq_d.size() > 0) && ordy[i]) begin
        if (eq_l[0]) mlines++;
        void'(eq_d.pop_front()); void'(eq_s.pop_front()); void'(eq_l.pop_front());
      end
      if (v[i] && exp_rdy) begin
        pend.push_back(d[i]);
        pos++;
        if ((pend.size() == 4) || (pos == lb)) begin
          w = '0;
          for (int k = 0; k < pend.size(); k++) w = w | (32'(pend[k]) << (8 * k));
          eq_d.push_back(w);
          eq_s.push_back(4'((1 << pend.size()) - 1));
          eq_l.push_back(pos == lb);
          if (pos == lb) pos = 0;
          pend.delete();
        end
      end
      @(posedge clk); #1;
    end
    v[i] = 1'b0; ordy[i] = 1'b1;
  endtask

  initial begin
    int i;
    int nw;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; d[k] = 8'h00; ordy[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_valid", k), 32'(oval[k]), 32'd0);
      chk($sformatf("rst%0d_data", k), odat[k], 32'd0);
      chk($sformatf("rst%0d_strb", k), 32'(ostrb[k]), 32'd0);
      chk($sformatf("rst%0d_last", k), 32'(olast[k]), 32'd0);
      chk($sformatf("rst%0d_lines", k), 32'(lines[k]), 32'd0);
      chk($sformatf("rst%0d_ready", k), 32'(irdy[k]), 32'd1);
    end
    do_reset();

    // LINE_BYTES=8, 6 and 1 directed lines, one record per cycle
    tbl.push_back(mk(1, 0, 1, 8'h01, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h02, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h03, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h04, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h05, 1, 32'h04030201, 4'hF, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h06, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h07, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h08, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 32'h08070605, 4'hF, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 32'h0, 4'h0, 0, 16'd1));
    tbl.push_back(mk(1, 1, 1, 8'h11, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 1, 8'h12, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 1, 8'h13, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 1, 8'h14, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 1, 8'h15, 1, 32'h14131211, 4'hF, 0, 16'd0));
    tbl.push_back(mk(0, 1, 1, 8'h16, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 32'h00001615, 4'h3, 1, 16'd0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 32'h0, 4'h0, 0, 16'd1));
    tbl.push_back(mk(1, 2, 1, 8'hAA, 0, 32'h0, 4'h0, 0, 16'd0));
    tbl.push_back(mk(0, 2, 1, 8'hBB, 1, 32'h000000AA, 4'h1, 1, 16'd0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 1, 32'h000000BB, 4'h1, 1, 16'd1));
    tbl.push_back(mk(0, 2, 0, 8'h00, 0, 32'h0, 4'h0, 0, 16'd2));

    foreach (tbl[n]) begin
      if (tbl[n].rst_before) do_reset();
      i = tbl[n].inst;
      v[i] = tbl[n].vv;
      d[i] = tbl[n].dd;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", n), 32'(irdy[i]), 32'd1);
      chk($sformatf("tbl%0d_valid", n), 32'(oval[i]), 32'(tbl[n].e_val));
      if (tbl[n].e_val) begin
        chk($sformatf("tbl%0d_data", n), odat[i], tbl[n].e_data);
        chk($sformatf("tbl%0d_strb", n), 32'(ostrb[i]), 32'(tbl[n].e_strb));
        chk($sformatf("tbl%0d_last", n), 32'(olast[i]), 32'(tbl[n].e_last));
      end
      chk($sformatf("tbl%0d_lines", n), 32'(lines[i]), 32'(tbl[n].e_lines));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) v[k] = 1'b0;

    // backpressure: the 8th byte must stall behind the held first word
    do_reset();
    ordy[0] = 1'b0;
    for (int b = 0; b < 7; b++) begin
      v[0] = 1'b1; d[0] = 8'(b + 1);
      @(negedge clk);
      chk($sformatf("bp_ready_b%0d", b + 1), 32'(irdy[0]), 32'd1);
      @(posedge clk); #1;
    end
    d[0] = 8'h08;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(irdy[0]), 32'd0);
      chk("bp_hold_valid", 32'(oval[0]), 32'd1);
      chk("bp_hold_data", odat[0], 32'h04030201);
      chk("bp_hold_strb", 32'(ostrb[0]), 32'hF);
      chk("bp_hold_last", 32'(olast[0]), 32'd0);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(irdy[0]), 32'd1);
    chk("bp_release_data", odat[0], 32'h04030201);
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(negedge clk);
    chk("bp_w2_valid", 32'(oval[0]), 32'd1);
    chk("bp_w2_data", odat[0], 32'h08070605);
    chk("bp_w2_strb", 32'(ostrb[0]), 32'hF);
    chk("bp_w2_last", 32'(olast[0]), 32'd1);
    chk("bp_w2_lines", 32'(lines[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_end_valid", 32'(oval[0]), 32'd0);
    chk("bp_end_lines", 32'(lines[0]), 32'd1);
    @(posedge clk); #1;

    // reset in the middle of a line, asserted between clock edges
    do_reset();
    for (int b = 0; b < 8; b++) begin
      v[0] = 1'b1; d[0] = 8'(8'h01 + b);
      @(posedge clk); #1;
    end
    v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mr_pre_lines", 32'(lines[0]), 32'd1);
    for (int b = 0; b < 3; b++) begin
      v[0] = 1'b1; d[0] = 8'(8'hA1 + b);
      @(posedge clk); #1;
    end
    v[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", 32'(oval[0]), 32'd0);
    chk("mr_data", odat[0], 32'd0);
    chk("mr_strb", 32'(ostrb[0]), 32'd0);
    chk("mr_last", 32'(olast[0]), 32'd0);
    chk("mr_lines", 32'(lines[0]), 32'd0);
    chk("mr_ready", 32'(irdy[0]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin v[0] = 1'b1; d[0] = 8'(8'h31 + c); end
      else v[0] = 1'b0;
      @(negedge clk);
      if (oval[0]) begin
        if (nw == 0) begin
          chk("mr_w1_data", odat[0], 32'h34333231);
          chk("mr_w1_last", 32'(olast[0]), 32'd0);
        end else begin
          chk("mr_w2_data", odat[0], 32'h38373635);
          chk("mr_w2_last", 32'(olast[0]), 32'd1);
        end
        nw++;
      end
      @(posedge clk); #1;
    end
    chk("mr_word_count", 32'(nw), 32'd2);
    chk("mr_fresh_lines", 32'(lines[0]), 32'd1);

    run_random(0, 800, 70, 60);
    run_random(1, 800, 70, 60);
    run_random(2, 800, 70, 60);
    run_random(0, 200, 100, 100);

    // lines_done wraps after 65536 single-byte lines
    do_reset();
    v[2] = 1'b1; ordy[2] = 1'b1;
    repeat (65536) begin
      d[2] = 8'($urandom);
      @(posedge clk);
    end
    #1;
    chk("wrap_ffff", 32'(lines[2]), 32'h0000FFFF);
    v[2] = 1'b0;
    @(posedge clk); #1;
    chk("wrap_zero", 32'(lines[2]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
